// File: rtl/rl_fifo_1r1w_ctrl_if.sv
// Client push/pop port plus the external 1R1W RAM port of the FWFT FIFO controller.
interface rl_fifo_1r1w_ctrl_if #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
);
  logic                     clr;
  logic                     push;
  logic [DBITS-1:0]         din;
  logic                     full;
  logic                     pop;
  logic [DBITS-1:0]         q;
  logic                     q_valid;
  logic [ABITS:0]           count;
  logic [ABITS-1:0]         ram_waddr;
  logic [DBITS-1:0]         ram_din;
  logic                     ram_we;
  logic [(DBITS+7)/8-1:0]   ram_be;
  logic [ABITS-1:0]         ram_raddr;
  logic                     ram_re;
  logic [DBITS-1:0]         ram_dout;

  modport master (
    output clr, push, din, pop, ram_dout,
    input  full, q, q_valid, count,
    input  ram_waddr, ram_din, ram_we, ram_be, ram_raddr, ram_re
  );

  modport slave (
    input  clr, push, din, pop, ram_dout,
    output full, q, q_valid, count,
    output ram_waddr, ram_din, ram_we, ram_be, ram_raddr, ram_re
  );
endinterface

// File: rtl/rl_fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO controller around an external registered-read 1R1W RAM,
// with a two-entry head/skid buffer absorbing the one-cycle RAM read latency.
module rl_fifo_1r1w_ctrl #(
  parameter int ABITS = 10,
  parameter int DBITS = 32
) (
  input  logic               clk,
  input  logic               rstn,
  rl_fifo_1r1w_ctrl_if.slave bus
);

  logic [ABITS-1:0] wptr, rptr;
  logic [ABITS:0]   ram_cnt, count;
  logic [1:0]       occ;
  logic             pend;
  logic [DBITS-1:0] head, skid;
  logic             full, q_valid, push_acc, pop_acc, re;
  logic [2:0]       buf_need;

  assign full     = (count == {1'b1, {ABITS{1'b0}}});
  assign q_valid  = (occ != 2'd0);
  assign push_acc = bus.push & ~full & ~bus.clr;
  assign pop_acc  = bus.pop & q_valid & ~bus.clr;

  // Buffer slots claimed next cycle; a read is only issued if its data will have a slot.
  assign buf_need = {1'b0, occ} + {2'b00, pend} - {2'b00, pop_acc};
  assign re       = ~bus.clr & (ram_cnt != '0) & (buf_need < 3'd2);

  assign bus.ram_we    = push_acc;
  assign bus.ram_waddr = wptr;
  assign bus.ram_din   = bus.din;
  assign bus.ram_be    = '1;
  assign bus.ram_re    = re;
  assign bus.ram_raddr = rptr;
  assign bus.full      = full;
  assign bus.q_valid   = q_valid;
  assign bus.count     = count;
  assign bus.q         = head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      count   <= '0;
      occ     <= '0;
      pend    <= 1'b0;
    end else if (bus.clr) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      count   <= '0;
      occ     <= '0;
      pend    <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (re)       rptr <= rptr + 1'b1;
      ram_cnt <= ram_cnt + {{ABITS{1'b0}}, push_acc} - {{ABITS{1'b0}}, re};
      count   <= count + {{ABITS{1'b0}}, push_acc} - {{ABITS{1'b0}}, pop_acc};
      occ     <= buf_need[1:0];
      pend    <= re;
    end
  end

  // occ==2 with pend never coexists, so arriving data always has a free slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      skid <= '0;
    end else if (!bus.clr) begin
      if (pop_acc && occ == 2'd2) begin
        head <= skid;
        if (pend) skid <= bus.ram_dout;
      end else if (pend && (occ == 2'd0 || pop_acc)) begin
        head <= bus.ram_dout;
      end else if (pend) begin
        skid <= bus.ram_dout;
      end
    end
  end

endmodule

// File: doc/rl_fifo_1r1w_ctrl.md
# rl_fifo_1r1w_ctrl

Synchronous first-word-fall-through FIFO controller that drives an external 1R1W block RAM (registered read, one-cycle latency, no read-during-write guarantee). It sits directly upstream of the RAM, generating its write and read ports, and directly downstream of it, consuming its read data into a two-entry output buffer. The client sees a push/pop FIFO with `q` valid whenever `q_valid` is high, and sustained throughput of one push and one pop per cycle.

## Interface
- `ABITS`, 10, RAM address width; capacity is 2**ABITS entries.
- `DBITS`, 32, data width.

- `rstn` input 1: asynchronous active-low reset.
- `clk` input 1: single clock; all state changes on the rising edge.
- `clr` input 1: synchronous flush, discards all entries.
- `push` input 1: write request.
- `din` input DBITS: write data.
- `full` output 1: high when `count` == 2**ABITS.
- `pop` input 1: consume the head entry.
- `q` output DBITS: head entry, registered.
- `q_valid` output 1: `q` holds a valid entry; high means not empty.
- `count` output ABITS+1: entries accepted and not yet popped, covering RAM, in-flight and buffer entries.
- `ram_waddr` output ABITS: RAM write address.
- `ram_din` output DBITS: RAM write data.
- `ram_we` output 1: RAM write enable.
- `ram_be` output (DBITS+7)/8: RAM byte enables, tied all-ones.
- `ram_raddr` output ABITS: RAM read address.
- `ram_re` output 1: RAM read enable.
- `ram_dout` input DBITS: RAM read data, valid in the cycle after `ram_re`.

## Operation
- Push accepted = `push & ~full & ~clr`. Pop accepted = `pop & q_valid & ~clr`. Non-accepted requests are ignored with no state change.
- Accepted push drives `ram_we`=1, `ram_waddr`=`wptr`, and `ram_din`=`din`, combinationally in the same cycle. `wptr` then increments modulo 2**ABITS.
- `full` is evaluated from the current `count` only. A push while full is ignored even if a pop is accepted in the same cycle.
- `ram_cnt` counts entries written to RAM and not yet read.
  - It increments one cycle after the write.
  - A read is therefore never issued to an address written in the same cycle, so there are no RAM collisions.
- Output buffer: 2 entries (head plus skid), with occupancy `occ` in 0..2. `pend` is 1 when a read was issued in the previous cycle, meaning its data is on `ram_dout` now.
- `ram_re` = `~clr & (ram_cnt != 0) & (occ + pend - pop_acc < 2)`. `ram_raddr` = `rptr`, which increments on every `ram_re`.
  - `ram_re` depends combinationally on `pop`.
- When `pend` is high, `ram_dout` is captured at the next edge. It goes into the head if the head is empty or being popped with the skid empty; otherwise it goes into the skid.
- On pop, skid data moves to the head. FIFO order is preserved.
- `count` next = `count` + push_acc - pop_acc. Simultaneous push and pop leaves it unchanged.
- `clr` does the following at the next edge:
  - Zeroes `wptr`, `rptr`, `ram_cnt`, `count` and `occ`.
  - Drops `pend` data.
  - Forces `q_valid`=0 and `full`=0.
  - Does not zero `q`.
- Invariant: `occ + pend + ram_cnt + (write committed this cycle)` = `count` ≤ 2**ABITS.

## Timing
- Reset values (asynchronous on `rstn` low): `q`=0, `q_valid`=0, `count`=0, `full`=0, `ram_we`=0, `ram_re`=0; all pointers 0, `occ`=0, `pend`=0.
- Push-to-`q_valid` latency into an empty FIFO is 3 cycles: push in cycle t, `ram_re` in t+1, `ram_dout` valid in t+2, `q_valid` high in t+3.
- A pop in cycle t advances `q` in t+1. Back-to-back pops with a steady stream sustain one pop per cycle with no bubbles once `occ`=2.
- `full` and `count` update one edge after the accepted push or pop.
- Pointer wrap: after address 2**ABITS-1, the next access uses address 0, with no stall.
- Deasserting reset mid-operation requires no recovery sequence; the first push is accepted in the first cycle after `rstn` goes high.

## Test plan
- Reset, then push 0xA5 in cycle 0 with no pop: `ram_we`=1 and `ram_waddr`=0 in cycle 0; `ram_re`=1 and `ram_raddr`=0 in cycle 1; `q`=0xA5 and `q_valid`=1 in cycle 3; `count`=1.
- ABITS=2: push 1,2,3,4, so `full`=1 and `count`=4. Push 5 together with a pop: 5 is dropped, `count`=3, and `q` sequence is 1,2,3,4 then `q_valid`=0.
- Continuous push and pop of 0..99 with ABITS=2: every value pops in order, no `q_valid` gaps after startup, and at least 2 pointer wraps occur.
- Push 0x11 and 0x22, then `clr` asserted while a read is pending: the next cycle shows `q_valid`=0 and `count`=0. A subsequent push of 0x33 is the next `q`.
- Pop and push asserted while empty: the pop is ignored and `count` does not underflow, ending at 1.
- Assert `rstn` low with `count`=3: all outputs immediately take their reset values without waiting for a clock edge.
